// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: sequences the G_L/A/B inputs of a 2-to-4 decoder to scan
// up to four multiplexed digits, skipping masked digits and inserting a
// blanking gap (G_L high) between digits to suppress ghosting.
module digit_scan_ctrl #(
    parameter int PRESCALE = 4,   // cycles each digit is driven (1..65535)
    parameter int BLANK    = 1    // blanking cycles between digits (0..65535)
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic [3:0] MASK,
    output logic       G_L,
    output logic       A,
    output logic       B,
    output logic       DIGIT_STROBE
);

    localparam int MAX_LOAD = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int CW       = $clog2(MAX_LOAD + 1);

    localparam logic [CW-1:0] PRE_LOAD   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK > 0) ? (BLANK - 1) : 0);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [1:0]    idx_reg, idx_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          g_l_reg, g_l_next;
    logic          strobe_reg, strobe_next;
    logic          run_ok;

    // First enabled digit searching start, start+1, start+2, start+3 (mod 4).
    function automatic logic [1:0] first_set(input logic [1:0] start, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] d;
        logic       found;
        r     = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = start + 2'(k);
            if (!found && m[d]) begin
                r     = d;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // First enabled digit searching start+1 .. start+4 (mod 4); the current
    // digit is only chosen again when it is the sole enabled one.
    function automatic logic [1:0] next_set(input logic [1:0] start, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] d;
        logic       found;
        r     = start;
        found = 1'b0;
        for (int k = 1; k < 5; k++) begin
            d = start + 2'(k);
            if (!found && m[d]) begin
                r     = d;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign run_ok = EN && (MASK != 4'b0000);

    // Next-state logic; a stop request (EN low or empty mask) overrides every
    // other transition, and the digit index only moves when entering ACTIVE.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        strobe_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run_ok) begin
                    state_next  = ACTIVE;
                    idx_next    = first_set(idx_reg, MASK);
                    cnt_next    = PRE_LOAD;
                    strobe_next = 1'b1;
                end
            end
            ACTIVE: begin
                if (!run_ok) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    if (BLANK > 0) begin
                        state_next = GAP;
                        cnt_next   = BLANK_LOAD;
                    end else begin
                        idx_next    = next_set(idx_reg, MASK);
                        cnt_next    = PRE_LOAD;
                        strobe_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            GAP: begin
                if (!run_ok) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next  = ACTIVE;
                    idx_next    = next_set(idx_reg, MASK);
                    cnt_next    = PRE_LOAD;
                    strobe_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        g_l_next = (state_next != ACTIVE);
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg  <= IDLE;
            idx_reg    <= 2'd0;
            cnt_reg    <= '0;
            g_l_reg    <= 1'b1;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            g_l_reg    <= g_l_next;
            strobe_reg <= strobe_next;
        end
    end

    assign G_L          = g_l_reg;
    assign A            = idx_reg[0];
    assign B            = idx_reg[1];
    assign DIGIT_STROBE = strobe_reg;

endmodule
